// File: rtl/pc_call_stack.sv
// Program counter with hardware return-address stack (CALL/RET) and interrupt-vector jump.
// Latency: one cycle, all outputs registered. Backpressure: none; every strobe acts on the next edge.
// Optional macro PC_STACK_TRAP_EN redirects any stack overflow/underflow to TRAP_ADDR.
module pc_call_stack #(
    parameter int              AW        = 10,
    parameter int              DEPTH     = 8,
    parameter logic [AW-1:0]   INT_VEC   = 'h3FF,
    parameter logic [AW-1:0]   TRAP_ADDR = 'h3FE
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [AW-1:0]                DIN,
    input  logic                         PC_LD,
    input  logic                         PC_INC,
    input  logic                         CALL,
    input  logic                         RET,
    input  logic                         INT_TAKE,
    output logic [AW-1:0]                PC_COUNT,
    output logic [$clog2(DEPTH+1)-1:0]   STK_DEPTH,
    output logic                         STK_EMPTY,
    output logic                         STK_FULL,
    output logic                         STK_ERR
);
    localparam int DW = $clog2(DEPTH+1);
    localparam int IW = $clog2(DEPTH);

    logic [AW-1:0] stk_mem [DEPTH];
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] pc_nxt;
    logic [AW-1:0] push_dat;
    logic [DW-1:0] depth_nxt;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic          push_en;
    logic          fault;
    logic          err_nxt;

    assign pc_inc    = PC_COUNT + AW'(1);
    assign wr_idx    = IW'(STK_DEPTH);
    assign rd_idx    = IW'(STK_DEPTH - DW'(1));
    assign STK_EMPTY = (STK_DEPTH == '0);
    assign STK_FULL  = (STK_DEPTH == DW'(DEPTH));

    // Priority chain selects exactly one action, so push and pop never coincide.
    always_comb begin
        pc_nxt    = PC_COUNT;
        depth_nxt = STK_DEPTH;
        err_nxt   = STK_ERR;
        push_en   = 1'b0;
        push_dat  = pc_inc;
        fault     = 1'b0;
        if (INT_TAKE || CALL) begin
            pc_nxt   = INT_TAKE ? INT_VEC : DIN;
            push_dat = INT_TAKE ? PC_COUNT : pc_inc;
            if (STK_FULL) begin
                fault = 1'b1;
            end else begin
                push_en   = 1'b1;
                depth_nxt = STK_DEPTH + DW'(1);
            end
        end else if (RET) begin
            if (STK_EMPTY) begin
                fault = 1'b1;
            end else begin
                pc_nxt    = stk_mem[rd_idx];
                depth_nxt = STK_DEPTH - DW'(1);
            end
        end else if (PC_LD) begin
            pc_nxt = DIN;
        end else if (PC_INC) begin
            pc_nxt = pc_inc;
        end
        if (fault) begin
            err_nxt = 1'b1;
        end
`ifdef PC_STACK_TRAP_EN
        if (fault) begin
            pc_nxt = TRAP_ADDR;
        end
`endif
    end

`ifndef PC_STACK_TRAP_EN
    logic unused_trap_addr;
    assign unused_trap_addr = ^TRAP_ADDR;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            PC_COUNT  <= '0;
            STK_DEPTH <= '0;
            STK_ERR   <= 1'b0;
        end else begin
            PC_COUNT  <= pc_nxt;
            STK_DEPTH <= depth_nxt;
            STK_ERR   <= err_nxt;
        end
    end

    // Stack storage needs no reset: depth alone defines which entries are live.
    always_ff @(posedge CLK) begin
        if (push_en) begin
            stk_mem[wr_idx] <= push_dat;
        end
    end
endmodule

// File: tb/tb_pc_call_stack.sv
// Directed testbench for pc_call_stack with default parameters (AW=10, DEPTH=8).
module tb_pc_call_stack;
    logic       CLK;
    logic       RST_N;
    logic [9:0] DIN;
    logic       PC_LD, PC_INC, CALL, RET, INT_TAKE;
    logic [9:0] PC_COUNT;
    logic [3:0] STK_DEPTH;
    logic       STK_EMPTY, STK_FULL, STK_ERR;

    int assertions = 0;
    int failures   = 0;

    pc_call_stack dut (
        .CLK(CLK), .RST_N(RST_N), .DIN(DIN),
        .PC_LD(PC_LD), .PC_INC(PC_INC), .CALL(CALL), .RET(RET), .INT_TAKE(INT_TAKE),
        .PC_COUNT(PC_COUNT), .STK_DEPTH(STK_DEPTH), .STK_EMPTY(STK_EMPTY),
        .STK_FULL(STK_FULL), .STK_ERR(STK_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Apply one cycle of strobes; returns 1 time unit after the edge with strobes cleared.
    task automatic cycle(input logic ld, input logic inc, input logic call, input logic ret,
                         input logic intt, input logic [9:0] din);
        PC_LD = ld; PC_INC = inc; CALL = call; RET = ret; INT_TAKE = intt; DIN = din;
        @(posedge CLK); #1;
        PC_LD = 0; PC_INC = 0; CALL = 0; RET = 0; INT_TAKE = 0;
    endtask

    task automatic test_reset;
        RST_N = 0;
        PC_LD = 0; PC_INC = 0; CALL = 0; RET = 0; INT_TAKE = 0; DIN = '0;
        repeat (2) @(posedge CLK);
        #1;
        assertions++; if (PC_COUNT !== 10'h000) begin failures++; $display("FAIL rst_pc: got %h want 000", PC_COUNT); end
        assertions++; if (STK_EMPTY !== 1'b1 || STK_FULL !== 1'b0) begin failures++; $display("FAIL rst_flags: empty %b full %b want 1 0", STK_EMPTY, STK_FULL); end
        RST_N = 1;
        cycle(0, 0, 0, 1, 0, 10'h000);  // underflow to make STK_ERR set before reset
        cycle(0, 0, 1, 0, 0, 10'h020);
        cycle(0, 0, 1, 0, 0, 10'h030);
        cycle(0, 0, 1, 0, 0, 10'h040);
        cycle(1, 0, 0, 0, 0, 10'h155);
        assertions++; if (PC_COUNT !== 10'h155 || STK_DEPTH !== 4'd3 || STK_ERR !== 1'b1) begin failures++; $display("FAIL pre_rst: pc %h depth %0d err %b want 155 3 1", PC_COUNT, STK_DEPTH, STK_ERR); end
        #3 RST_N = 0;
        #1;
        assertions++; if (PC_COUNT !== 10'h000) begin failures++; $display("FAIL async_rst_pc: got %h want 000", PC_COUNT); end
        assertions++; if (STK_DEPTH !== 4'd0 || STK_EMPTY !== 1'b1) begin failures++; $display("FAIL async_rst_depth: depth %0d empty %b want 0 1", STK_DEPTH, STK_EMPTY); end
        assertions++; if (STK_ERR !== 1'b0 || STK_FULL !== 1'b0) begin failures++; $display("FAIL async_rst_err: err %b full %b want 0 0", STK_ERR, STK_FULL); end
        @(posedge CLK); #1;
        RST_N = 1;
    endtask

    task automatic test_inc_load_wrap;
        cycle(1, 0, 0, 0, 0, 10'h3FE);
        assertions++; if (PC_COUNT !== 10'h3FE) begin failures++; $display("FAIL ld_3fe: got %h want 3fe", PC_COUNT); end
        cycle(0, 1, 0, 0, 0, 10'h000);
        assertions++; if (PC_COUNT !== 10'h3FF) begin failures++; $display("FAIL inc_3ff: got %h want 3ff", PC_COUNT); end
        cycle(0, 1, 0, 0, 0, 10'h000);
        assertions++; if (PC_COUNT !== 10'h000 || STK_ERR !== 1'b0) begin failures++; $display("FAIL wrap: pc %h err %b want 000 0", PC_COUNT, STK_ERR); end
        cycle(1, 1, 0, 0, 0, 10'h040);
        assertions++; if (PC_COUNT !== 10'h040 || STK_DEPTH !== 4'd0) begin failures++; $display("FAIL ld_over_inc: pc %h depth %0d want 040 0", PC_COUNT, STK_DEPTH); end
        cycle(0, 0, 0, 0, 0, 10'h123);
        assertions++; if (PC_COUNT !== 10'h040) begin failures++; $display("FAIL hold: got %h want 040", PC_COUNT); end
    endtask

    task automatic test_call_ret;
        cycle(1, 0, 0, 0, 0, 10'h010);
        cycle(1, 1, 1, 0, 0, 10'h100);  // CALL outranks PC_LD/PC_INC
        assertions++; if (PC_COUNT !== 10'h100 || STK_DEPTH !== 4'd1 || STK_EMPTY !== 1'b0) begin failures++; $display("FAIL call1: pc %h depth %0d empty %b want 100 1 0", PC_COUNT, STK_DEPTH, STK_EMPTY); end
        cycle(0, 0, 1, 0, 0, 10'h200);
        assertions++; if (PC_COUNT !== 10'h200 || STK_DEPTH !== 4'd2) begin failures++; $display("FAIL call2: pc %h depth %0d want 200 2", PC_COUNT, STK_DEPTH); end
        cycle(1, 1, 0, 1, 0, 10'h3AA);  // RET outranks PC_LD/PC_INC
        assertions++; if (PC_COUNT !== 10'h101 || STK_DEPTH !== 4'd1) begin failures++; $display("FAIL ret1: pc %h depth %0d want 101 1", PC_COUNT, STK_DEPTH); end
        cycle(0, 0, 0, 1, 0, 10'h000);
        assertions++; if (PC_COUNT !== 10'h011 || STK_DEPTH !== 4'd0 || STK_EMPTY !== 1'b1) begin failures++; $display("FAIL ret2: pc %h depth %0d empty %b want 011 0 1", PC_COUNT, STK_DEPTH, STK_EMPTY); end
    endtask

    task automatic test_interrupt;
        cycle(1, 0, 0, 0, 0, 10'h050);
        cycle(1, 1, 1, 1, 1, 10'h123);
        assertions++; if (PC_COUNT !== 10'h3FF || STK_DEPTH !== 4'd1) begin failures++; $display("FAIL int_take: pc %h depth %0d want 3ff 1", PC_COUNT, STK_DEPTH); end
        cycle(0, 0, 0, 1, 0, 10'h000);
        assertions++; if (PC_COUNT !== 10'h050 || STK_DEPTH !== 4'd0) begin failures++; $display("FAIL int_ret: pc %h depth %0d want 050 0", PC_COUNT, STK_DEPTH); end
    endtask

    // Fill from PC=0x020 with CALL targets 0x100,0x110,...,0x170.
    // Pushed return addresses: 0x021, then 0x101,0x111,...,0x161.
    task automatic fill_stack(output logic [9:0] exp_ret [8]);
        cycle(1, 0, 0, 0, 0, 10'h020);
        exp_ret[0] = 10'h021;
        for (int k = 1; k < 8; k++) exp_ret[k] = 10'h101 + 10'(k - 1) * 10'h010;
        for (int k = 0; k < 8; k++) cycle(0, 0, 1, 0, 0, 10'h100 + 10'(k) * 10'h010);
        assertions++; if (STK_FULL !== 1'b1 || STK_DEPTH !== 4'd8 || PC_COUNT !== 10'h170) begin failures++; $display("FAIL fill: full %b depth %0d pc %h want 1 8 170", STK_FULL, STK_DEPTH, PC_COUNT); end
        assertions++; if (STK_ERR !== 1'b0) begin failures++; $display("FAIL fill_err: got %b want 0", STK_ERR); end
    endtask

`ifndef PC_STACK_TRAP_EN
    task automatic test_overflow_underflow;
        logic [9:0] exp_ret [8];
        fill_stack(exp_ret);
        cycle(0, 0, 1, 0, 0, 10'h080);
        assertions++; if (PC_COUNT !== 10'h080 || STK_DEPTH !== 4'd8 || STK_ERR !== 1'b1) begin failures++; $display("FAIL overflow: pc %h depth %0d err %b want 080 8 1", PC_COUNT, STK_DEPTH, STK_ERR); end
        for (int k = 7; k >= 0; k--) begin
            cycle(0, 0, 0, 1, 0, 10'h000);
            assertions++; if (PC_COUNT !== exp_ret[k] || STK_DEPTH !== 4'(k)) begin failures++; $display("FAIL lifo_%0d: pc %h depth %0d want %h %0d", k, PC_COUNT, STK_DEPTH, exp_ret[k], k); end
        end
        cycle(0, 0, 0, 1, 0, 10'h000);
        assertions++; if (PC_COUNT !== 10'h021 || STK_DEPTH !== 4'd0 || STK_ERR !== 1'b1) begin failures++; $display("FAIL underflow: pc %h depth %0d err %b want 021 0 1", PC_COUNT, STK_DEPTH, STK_ERR); end
    endtask
`else
    task automatic test_trap;
        logic [9:0] exp_ret [8];
        @(posedge CLK); #3 RST_N = 0;
        @(posedge CLK); #1 RST_N = 1;
        cycle(0, 0, 0, 1, 0, 10'h000);
        assertions++; if (PC_COUNT !== 10'h3FE || STK_ERR !== 1'b1 || STK_DEPTH !== 4'd0) begin failures++; $display("FAIL trap_underflow: pc %h err %b depth %0d want 3fe 1 0", PC_COUNT, STK_ERR, STK_DEPTH); end
        @(posedge CLK); #3 RST_N = 0;
        @(posedge CLK); #1 RST_N = 1;
        fill_stack(exp_ret);
        cycle(0, 0, 1, 0, 0, 10'h080);
        assertions++; if (PC_COUNT !== 10'h3FE || STK_DEPTH !== 4'd8 || STK_ERR !== 1'b1) begin failures++; $display("FAIL trap_overflow: pc %h depth %0d err %b want 3fe 8 1", PC_COUNT, STK_DEPTH, STK_ERR); end
        cycle(0, 0, 0, 1, 0, 10'h000);
        assertions++; if (PC_COUNT !== exp_ret[7] || STK_DEPTH !== 4'd7) begin failures++; $display("FAIL trap_top: pc %h depth %0d want %h 7", PC_COUNT, STK_DEPTH, exp_ret[7]); end
    endtask
`endif

    initial begin
        test_reset();
        test_inc_load_wrap();
        test_call_ret();
        test_interrupt();
`ifndef PC_STACK_TRAP_EN
        test_overflow_underflow();
`else
        test_trap();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
